// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter slice (FSM encoding, port indices).
// Used by dm_arbiter and dm_arb_pick; optional build macro DM_ARB_RR_EN lives in dm_arb_pick.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection between the CPU and debug ports.
// Default: fixed priority with starvation limit; DM_ARB_RR_EN selects strict round-robin.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic [1:0]       req_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  input  logic             last_owner_i,
  output logic             win_valid_o,
  output logic             win_idx_o
);

  logic tie_idx_s;
  logic unused_s;

`ifdef DM_ARB_RR_EN
  assign unused_s = ^{starve_cnt_i, CNT_W'(STARVE_LIMIT)};

  // Ties go to whichever port was not granted last.
  always_comb begin
    tie_idx_s = ~last_owner_i;
  end
`else
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  assign unused_s = last_owner_i;

  // CPU wins ties until the debug port has waited through LIMIT_C CPU grants.
  always_comb begin
    if (starve_cnt_i >= LIMIT_C) begin
      tie_idx_s = PORT_DBG;
    end else begin
      tie_idx_s = PORT_CPU;
    end
  end
`endif

  always_comb begin
    win_valid_o = 1'b0;
    win_idx_o   = PORT_CPU;
    case (req_i)
      2'b01: begin
        win_valid_o = 1'b1;
        win_idx_o   = PORT_CPU;
      end
      2'b10: begin
        win_valid_o = 1'b1;
        win_idx_o   = PORT_DBG;
      end
      2'b11: begin
        win_valid_o = 1'b1;
        win_idx_o   = tie_idx_s;
      end
      default: begin
        win_valid_o = 1'b0;
        win_idx_o   = PORT_CPU;
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer serialising word accesses onto the single-port data memory.
// Build option: define DM_ARB_RR_EN for strict round-robin arbitration (see dm_arb_pick).
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_ad,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_ad,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_wrdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_dm
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cmd_ad_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              cmd_we_q;
  logic              cmd_port_q;
  logic              mem_wr_q;
  logic              p0_rvalid_q, p1_rvalid_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              owner_q, owner_d;

  logic              win_valid_s;
  logic              win_idx_s;
  logic              accept_win_s;
  logic              accept_s;
  logic [ADDR_W-1:0] sel_ad_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_we_s;

  dm_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .req_i        ({p1_req, p0_req}),
    .starve_cnt_i (starve_q),
    .last_owner_i (owner_q),
    .win_valid_o  (win_valid_s),
    .win_idx_o    (win_idx_s)
  );

  // A latched read blocks acceptance because its data still has to come back through RESP.
  assign accept_win_s = (state_q == IDLE) || (state_q == RESP) ||
                        ((state_q == ACCESS) && cmd_we_q);
  assign accept_s     = accept_win_s & win_valid_s & Rst_n;
  assign p0_gnt       = accept_s & (win_idx_s == PORT_CPU);
  assign p1_gnt       = accept_s & (win_idx_s == PORT_DBG);

  assign sel_ad_s    = (win_idx_s == PORT_DBG) ? p1_ad    : p0_ad;
  assign sel_wdata_s = (win_idx_s == PORT_DBG) ? p1_wdata : p0_wdata;
  assign sel_we_s    = (win_idx_s == PORT_DBG) ? p1_we    : p0_we;

  always_comb begin
    state_d = IDLE;
    if (accept_s) begin
      state_d = ACCESS;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCESS:  state_d = cmd_we_q ? IDLE : RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Starvation count only runs while the debug port is actually waiting.
  always_comb begin
    starve_d = starve_q;
    owner_d  = owner_q;
    if (!p1_req) begin
      starve_d = '0;
    end else if (p1_gnt) begin
      starve_d = '0;
    end else if (p0_gnt) begin
      starve_d = sat_inc(starve_q);
    end else begin
      starve_d = starve_q;
    end
    if (accept_s) begin
      owner_d = win_idx_s;
    end else begin
      owner_d = owner_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cmd_ad_q    <= '0;
      cmd_wdata_q <= '0;
      cmd_we_q    <= 1'b0;
      cmd_port_q  <= PORT_CPU;
      mem_wr_q    <= 1'b0;
      starve_q    <= '0;
      owner_q     <= PORT_CPU;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      mem_wr_q <= accept_s & sel_we_s;
      if (accept_s) begin
        cmd_ad_q    <= sel_ad_s;
        cmd_wdata_q <= sel_wdata_s;
        cmd_we_q    <= sel_we_s;
        cmd_port_q  <= win_idx_s;
      end else begin
        cmd_ad_q    <= cmd_ad_q;
        cmd_wdata_q <= cmd_wdata_q;
        cmd_we_q    <= cmd_we_q;
        cmd_port_q  <= cmd_port_q;
      end
    end
  end

  // Memory data is valid during RESP; steer it to the owning port, leaving the other port's data intact.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      if ((state_q == RESP) && (cmd_port_q == PORT_CPU)) begin
        p0_rvalid_q <= 1'b1;
        p0_rdata_q  <= mem_dm;
      end else begin
        p0_rvalid_q <= 1'b0;
        p0_rdata_q  <= p0_rdata_q;
      end
      if ((state_q == RESP) && (cmd_port_q == PORT_DBG)) begin
        p1_rvalid_q <= 1'b1;
        p1_rdata_q  <= mem_dm;
      end else begin
        p1_rvalid_q <= 1'b0;
        p1_rdata_q  <= p1_rdata_q;
      end
    end
  end

  assign mem_ad     = cmd_ad_q;
  assign mem_wrdata = cmd_wdata_q;
  assign mem_wr     = mem_wr_q;
  assign p0_rvalid  = p0_rvalid_q;
  assign p1_rvalid  = p1_rvalid_q;
  assign p0_rdata   = p0_rdata_q;
  assign p1_rdata   = p1_rdata_q;

endmodule
